dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter granting two requesters one data-memory access at a time
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic                  req0_we,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic                  rsp0_err,
    output logic                  rsp1_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    state_e state_q, state_d;
    logic last_q, last_d, port_q, port_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic idle, grant, misaligned;

    assign idle       = state_q == IDLE;
    // On a tie the requester not served last wins
    assign grant      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = idle & req0_valid & ~grant;
    assign req1_ready = idle & req1_valid & grant;
    assign misaligned = |addr_q[1:0];
    // Strobes are masked by reset so an in-flight write cannot land on the reset edge
    assign mem_wr_en  = ~reset & (state_q == ACCESS) & we_q & ~misaligned;
    assign rsp0_valid = ~reset & (state_q == RESP) & ~port_q;
    assign rsp1_valid = ~reset & (state_q == RESP) & port_q;
    assign rsp0_err   = rsp0_valid & misaligned;
    assign rsp1_err   = rsp1_valid & misaligned;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign rsp_rdata  = rdata_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req0_ready | req1_ready) begin
                state_d = ACCESS;
                last_d  = grant;
                port_d  = grant;
                we_d    = grant ? req1_we : req0_we;
                addr_d  = grant ? req1_addr : req0_addr;
                wdata_d = grant ? req1_wdata : req0_wdata;
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = we_q ? rdata_q : (misaligned ? '0 : mem_rd_data);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios against a small word-addressed memory model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready, req0_we, req1_we;
    logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rd_data;
    logic        mem_wr_en;
    logic [31:0] mem [0:63];
    int total = 0;
    int bad = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_we(req0_we), .req1_we(req1_we),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
        .rsp_rdata(rsp_rdata), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;
    assign mem_rd_data = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end
    endtask

    // One complete access from an idle arbiter; the requester drops valid right after the handshake
    task automatic run_access(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                              input bit exp_err, input logic [31:0] exp_rdata, input string nm);
        drive(p, 1'b1, we, a, d);
        #1;
        total++; if ((p ? req1_ready : req0_ready) !== 1'b1 || (p ? req0_ready : req1_ready) !== 1'b0) begin
            bad++; $display("FAIL %s ready: got r0=%b r1=%b want port %0d only", nm, req0_ready, req1_ready, p);
        end
        cyc;
        drive(p, 1'b0, ~we, a + 32'h4, ~d);
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++; $display("FAIL %s access_ready: got r0=%b r1=%b want 0", nm, req0_ready, req1_ready);
        end
        total++; if (mem_wr_en !== (we && a[1:0] == 2'b00) || mem_addr !== a) begin
            bad++; $display("FAIL %s access: got we=%b addr=%h want we=%b addr=%h", nm, mem_wr_en, mem_addr, we && a[1:0] == 2'b00, a);
        end
        if (we) begin
            total++; if (mem_wdata !== d) begin
                bad++; $display("FAIL %s wdata: got %h want %h", nm, mem_wdata, d);
            end
        end
        cyc;
        #1;
        total++; if ((p ? rsp1_valid : rsp0_valid) !== 1'b1 || (p ? rsp0_valid : rsp1_valid) !== 1'b0) begin
            bad++; $display("FAIL %s rsp_valid: got v0=%b v1=%b want port %0d only", nm, rsp0_valid, rsp1_valid, p);
        end
        total++; if ((p ? rsp1_err : rsp0_err) !== exp_err) begin
            bad++; $display("FAIL %s rsp_err: got %b want %b", nm, p ? rsp1_err : rsp0_err, exp_err);
        end
        if (!we) begin
            total++; if (rsp_rdata !== exp_rdata) begin
                bad++; $display("FAIL %s rdata: got %h want %h", nm, rsp_rdata, exp_rdata);
            end
        end
        cyc;
        #1;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            bad++; $display("FAIL %s rsp_pulse: got v0=%b v1=%b want 0", nm, rsp0_valid, rsp1_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        cyc;
        cyc;
        #1;
        total++; if ({mem_wr_en, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready} !== 7'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 0", {mem_wr_en, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready});
        end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_regs: got addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rsp_rdata);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_tie: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc;
        reset = 1'b0;
    endtask

    task automatic test_write_read;
        run_access(0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, "write");
        total++; if (mem[4] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL write_mem: got %h want deadbeef", mem[4]);
        end
        run_access(1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, "readback");
    endtask

    task automatic test_misaligned;
        run_access(0, 1, 32'h13, 32'h12345678, 1, 32'h0, "mis_write");
        total++; if (mem[4] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL mis_mem: got %h want deadbeef", mem[4]);
        end
        run_access(1, 0, 32'h11, 32'h0, 1, 32'h0, "mis_read");
        run_access(0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, "read_after_mis");
    endtask

    task automatic test_contention;
        reset = 1'b1;
        drive(0, 1, 0, 32'h10, 0);
        drive(1, 1, 0, 32'h10, 0);
        cyc;
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bit g;
            g = ((k / 3) % 2) == 1;
            #1;
            if (k % 3 == 0) begin
                total++; if (req0_ready !== !g || req1_ready !== g) begin
                    bad++; $display("FAIL contention_grant%0d: got r0=%b r1=%b want port %0d", k / 3, req0_ready, req1_ready, g);
                end
            end else if (k % 3 == 2) begin
                total++; if (rsp0_valid !== !g || rsp1_valid !== g || rsp_rdata !== 32'hDEADBEEF) begin
                    bad++; $display("FAIL contention_rsp%0d: got v0=%b v1=%b rdata=%h want port %0d deadbeef", k / 3, rsp0_valid, rsp1_valid, rsp_rdata, g);
                end
            end else begin
                total++; if ({req0_ready, req1_ready, mem_wr_en} !== 3'b000) begin
                    bad++; $display("FAIL contention_busy%0d: got %b want 000", k / 3, {req0_ready, req1_ready, mem_wr_en});
                end
            end
            cyc;
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        cyc;
    endtask

    task automatic test_withdraw;
        drive(0, 1, 0, 32'h10, 0);
        #1;
        cyc;
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 32'h30, 32'h55AA55AA);
        #1;
        total++; if (req1_ready !== 1'b0) begin
            bad++; $display("FAIL withdraw_busy: got r1=%b want 0", req1_ready);
        end
        cyc;
        #1;
        total++; if (req1_ready !== 1'b0 || rsp0_valid !== 1'b1) begin
            bad++; $display("FAIL withdraw_resp: got r1=%b v0=%b want r1=0 v0=1", req1_ready, rsp0_valid);
        end
        drive(1, 0, 1, 32'h30, 32'h55AA55AA);
        cyc;
        cyc;
        #1;
        total++; if ({mem_wr_en, rsp1_valid} !== 2'b00 || mem[12] !== 32'h0) begin
            bad++; $display("FAIL withdraw_noaccess: got we=%b v1=%b mem=%h want 0", mem_wr_en, rsp1_valid, mem[12]);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            bad++; $display("FAIL withdraw_rr: got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc;
    endtask

    task automatic test_reset_mid;
        drive(0, 1, 1, 32'h20, 32'hCAFEF00D);
        #1;
        cyc;
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        total++; if (mem_wr_en !== 1'b0) begin
            bad++; $display("FAIL rstmid_wr: got %b want 0", mem_wr_en);
        end
        cyc;
        reset = 1'b0;
        #1;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL rstmid_state: got v0=%b v1=%b addr=%h want 0", rsp0_valid, rsp1_valid, mem_addr);
        end
        cyc;
        #1;
        total++; if ({rsp0_valid, rsp1_valid, mem_wr_en} !== 3'b000 || mem[8] !== 32'h0) begin
            bad++; $display("FAIL rstmid_nowrite: got %b mem=%h want 000 00000000", {rsp0_valid, rsp1_valid, mem_wr_en}, mem[8]);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_tie: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset;
        test_write_read;
        test_misaligned;
        test_contention;
        test_withdraw;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
